loop_sequencer: RTL and testbench

Controller that sequences a two-level nested loop (outer x inner) for accelerator datapaths. Each loop index is a mod-N counter. The block emits one (outer_idx, inner_idx) pair per accepted handshake, in row-major order. It sits between the top-level start/done wrapper and the datapath stage that consumes index pairs.

---
 rtl/loop_sequencer.sv | 88 ++++++++
 tb/tb_loop_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/loop_sequencer.sv
// Two-level nested loop sequencer: emits (outer_idx, inner_idx) pairs in row-major order, one per valid&ready.
// Optional feature: define LOOP_SEQ_ABORT_EN to add an abort input that cancels a running sequence.
module loop_sequencer #(
  parameter int N_OUTER = 4,
  parameter int N_INNER = 5,
  parameter int OBITS   = 2,
  parameter int IBITS   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ready,
`ifdef LOOP_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             valid,
  output logic [OBITS-1:0] outer_idx,
  output logic [IBITS-1:0] inner_idx,
  output logic             last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;
  logic   inner_end;
  logic   outer_end;
  logic   kill;

  // Wrap is decided by the trip-count compare alone, never by counter overflow.
  assign inner_end = (inner_idx == IBITS'(N_INNER - 1));
  assign outer_end = (outer_idx == OBITS'(N_OUTER - 1));

`ifdef LOOP_SEQ_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // NOTE: state and counters use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      outer_idx <= '0;
      inner_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            outer_idx <= '0;
            inner_idx <= '0;
          end
        end
        RUN: begin
          if (kill) begin
            // Abort wins over a transfer in the same cycle.
            state     <= IDLE;
            outer_idx <= '0;
            inner_idx <= '0;
          end else if (ready) begin
            if (inner_end) begin
              inner_idx <= '0;
              if (outer_end) begin
                outer_idx <= '0;
                state     <= DONE;
              end else begin
                outer_idx <= outer_idx + OBITS'(1);
              end
            end else begin
              inner_idx <= inner_idx + IBITS'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state and counters.
  assign valid = (state == RUN);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign last  = valid & inner_end & outer_end;

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer: a 3x2 instance for the main scenarios and a 1x1 instance for the degenerate case.
module tb_loop_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start_a, ready_a, start_b, ready_b;
  logic valid_a, last_a, busy_a, done_a;
  logic [1:0] outer_a;
  logic [2:0] inner_a;
  logic valid_b, last_b, busy_b, done_b;
  logic [0:0] outer_b;
  logic [0:0] inner_b;
`ifdef LOOP_SEQ_ABORT_EN
  logic abort_a, abort_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  loop_sequencer #(.N_OUTER(3), .N_INNER(2), .OBITS(2), .IBITS(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ready(ready_a),
`ifdef LOOP_SEQ_ABORT_EN
    .abort(abort_a),
`endif
    .valid(valid_a), .outer_idx(outer_a), .inner_idx(inner_a),
    .last(last_a), .busy(busy_a), .done(done_a)
  );

  loop_sequencer #(.N_OUTER(1), .N_INNER(1), .OBITS(1), .IBITS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ready(ready_b),
`ifdef LOOP_SEQ_ABORT_EN
    .abort(abort_b),
`endif
    .valid(valid_b), .outer_idx(outer_b), .inner_idx(inner_b),
    .last(last_b), .busy(busy_b), .done(done_b)
  );

  // Observed word layout: {valid, outer, inner, last, busy, done}
  logic [8:0] obs_a;
  logic [5:0] obs_b;
  assign obs_a = {valid_a, outer_a, inner_a, last_a, busy_a, done_a};
  assign obs_b = {valid_b, outer_b, inner_b, last_b, busy_b, done_b};

  localparam logic [8:0] E_IDLE = 9'b0_00_000_000;
  localparam logic [8:0] E_DONE = 9'b0_00_000_011;

  function automatic logic [8:0] pa(input int o, input int i, input logic l);
    return {1'b1, o[1:0], i[2:0], l, 1'b1, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++;
    if (obs_a !== E_IDLE) begin
      n_err++; $display("FAIL reset_a: got %b expected %b", obs_a, E_IDLE);
    end
    n_cmp++;
    if (obs_b !== 6'b0) begin
      n_err++; $display("FAIL reset_b: got %b expected %b", obs_b, 6'b0);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (obs_a !== E_IDLE) begin
      n_err++; $display("FAIL post_reset_idle: got %b expected %b", obs_a, E_IDLE);
    end
    // Start a run, then assert reset mid-cycle at (1,0)
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (obs_a !== pa(1, 0, 1'b0)) begin
      n_err++; $display("FAIL pre_async_reset: got %b expected %b", obs_a, pa(1, 0, 1'b0));
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs_a !== E_IDLE) begin
      n_err++; $display("FAIL async_reset_mid_cycle: got %b expected %b", obs_a, E_IDLE);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (obs_a !== E_IDLE) begin
        n_err++; $display("FAIL reset_no_done cycle %0d: got %b expected %b", c, obs_a, E_IDLE);
      end
    end
  endtask

  task automatic test_full_run();
    logic [8:0] exp_v;
    start_a = 1'b1;
    ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c <= 6)      exp_v = pa((c - 1) / 2, (c - 1) % 2, c == 6);
      else if (c == 7) exp_v = E_DONE;
      else             exp_v = E_IDLE;
      n_cmp++;
      if (obs_a !== exp_v) begin
        n_err++; $display("FAIL full_run cycle %0d: got %b expected %b", c, obs_a, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp_t [11];
    logic       rdy_t [11];
    exp_t = '{pa(0, 0, 1'b0), pa(0, 1, 1'b0), pa(1, 0, 1'b0), pa(1, 0, 1'b0),
              pa(1, 0, 1'b0), pa(1, 0, 1'b0), pa(1, 1, 1'b0), pa(2, 0, 1'b0),
              pa(2, 1, 1'b1), E_DONE, E_IDLE};
    rdy_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    start_a = 1'b1;
    ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 11; c++) begin
      n_cmp++;
      if (obs_a !== exp_t[c]) begin
        n_err++; $display("FAIL backpressure cycle %0d: got %b expected %b", c + 1, obs_a, exp_t[c]);
      end
      ready_a = rdy_t[c];
      tick();
    end
    ready_a = 1'b1;
  endtask

  task automatic test_ignored_start();
    logic [8:0] exp_v;
    start_a = 1'b1;
    ready_a = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      if (c <= 6)       exp_v = pa((c - 1) / 2, (c - 1) % 2, c == 6);
      else if (c == 7)  exp_v = E_DONE;
      else if (c == 8)  exp_v = E_IDLE;
      else if (c <= 14) exp_v = pa((c - 9) / 2, (c - 9) % 2, c == 14);
      else if (c == 15) exp_v = E_DONE;
      else              exp_v = E_IDLE;
      n_cmp++;
      if (obs_a !== exp_v) begin
        n_err++; $display("FAIL ignored_start cycle %0d: got %b expected %b", c, obs_a, exp_v);
      end
      if (c == 9) start_a = 1'b0;
      tick();
    end
  endtask

  task automatic test_degenerate();
    logic [5:0] exp_t [3];
    exp_t = '{6'b100110, 6'b000011, 6'b000000};
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (obs_b !== exp_t[c]) begin
        n_err++; $display("FAIL degenerate cycle %0d: got %b expected %b", c + 1, obs_b, exp_t[c]);
      end
      tick();
    end
  endtask

`ifdef LOOP_SEQ_ABORT_EN
  task automatic test_abort();
    logic [8:0] exp_t [4];
    exp_t = '{pa(0, 0, 1'b0), pa(0, 1, 1'b0), pa(1, 0, 1'b0), pa(1, 1, 1'b0)};
    start_a = 1'b1;
    ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (obs_a !== exp_t[c]) begin
        n_err++; $display("FAIL abort_pre cycle %0d: got %b expected %b", c + 1, obs_a, exp_t[c]);
      end
      if (c == 3) abort_a = 1'b1;
      tick();
    end
    abort_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (obs_a !== E_IDLE) begin
        n_err++; $display("FAIL abort_idle cycle %0d: got %b expected %b", c, obs_a, E_IDLE);
      end
      tick();
    end
    test_full_run();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    ready_a = 1'b1;
    start_b = 1'b0;
    ready_b = 1'b1;
`ifdef LOOP_SEQ_ABORT_EN
    abort_a = 1'b0;
    abort_b = 1'b0;
`endif
    test_reset();
    test_full_run();
    test_backpressure();
    test_ignored_start();
    test_degenerate();
`ifdef LOOP_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
